// File: rtl/eth_pcs_pkg.sv
// eth_pcs_pkg: shared 10GBASE-R sync-header constants, block-lock FSM states and header check
package eth_pcs_pkg;
  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;
  typedef enum logic [1:0] {INIT, TEST_SH, SLIP} bl_fsm_t;
  function automatic logic sh_is_valid(input logic [1:0] sh);
    return sh == SH_DATA || sh == SH_CTRL;
  endfunction
endpackage

// File: rtl/eth_block_lock_lane.sv
// eth_block_lock_lane: one lane's sync-header window test, bitslip request and slip statistics
module eth_block_lock_lane
  import eth_pcs_pkg::*;
#(
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int LOCK_WINDOWS   = 1,
  parameter int SLIP_WAIT      = 32
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] header,
  input  logic       header_valid,
  input  logic       clear_stats,
  output logic       block_lock,
  output logic       rxslip,
  output logic [7:0] slip_count
);
  localparam int CW = $clog2(SH_CNT_MAX + 1);
  localparam int IW = $clog2(SH_INVALID_MAX + 1);
  localparam int GW = $clog2(LOCK_WINDOWS + 1);
  localparam int WW = SLIP_WAIT > 0 ? $clog2(SLIP_WAIT + 1) : 1;
  bl_fsm_t state, state_n;
  logic [CW-1:0] sh_cnt, sh_cnt_n, cnt_n;
  logic [IW-1:0] inv_cnt, inv_cnt_n, inv_n;
  logic [GW-1:0] good_win, good_win_n;
  logic [WW-1:0] wait_cnt, wait_cnt_n;
  logic lock_n, rxslip_n, slip;
  logic [7:0] slip_count_n;
  assign cnt_n = sh_cnt + 1'b1;
  assign inv_n = inv_cnt + IW'(!sh_is_valid(header));
  // Unlocked lanes slip on any bad header; locked lanes only once the window's bad budget is spent
  assign slip = state == TEST_SH && header_valid &&
                (block_lock ? inv_n == IW'(SH_INVALID_MAX) : !sh_is_valid(header));
  always_comb begin
    state_n      = state;
    sh_cnt_n     = sh_cnt;
    inv_cnt_n    = inv_cnt;
    good_win_n   = good_win;
    wait_cnt_n   = wait_cnt;
    lock_n       = block_lock;
    rxslip_n     = 1'b0;
    slip_count_n = clear_stats ? 8'd0 : (slip && slip_count != 8'hff) ? slip_count + 8'd1 : slip_count;
    case (state)
      INIT: begin
        state_n    = TEST_SH;
        sh_cnt_n   = '0;
        inv_cnt_n  = '0;
        good_win_n = '0;
        wait_cnt_n = '0;
        lock_n     = 1'b0;
      end
      TEST_SH:
        if (slip) begin
          state_n    = SLIP;
          rxslip_n   = 1'b1;
          lock_n     = 1'b0;
          good_win_n = '0;
          sh_cnt_n   = '0;
          inv_cnt_n  = '0;
          wait_cnt_n = WW'(SLIP_WAIT);
        end else if (header_valid) begin
          if (cnt_n == CW'(SH_CNT_MAX)) begin
            sh_cnt_n  = '0;
            inv_cnt_n = '0;
            if (!block_lock) begin
              good_win_n = good_win + 1'b1;
              lock_n     = good_win + 1'b1 == GW'(LOCK_WINDOWS);
            end
          end else begin
            sh_cnt_n  = cnt_n;
            inv_cnt_n = inv_n;
          end
        end
      SLIP:
        if (wait_cnt == '0) state_n = TEST_SH;
        else wait_cnt_n = wait_cnt - 1'b1;
      default: state_n = INIT;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state      <= INIT;
      sh_cnt     <= '0;
      inv_cnt    <= '0;
      good_win   <= '0;
      wait_cnt   <= '0;
      block_lock <= 1'b0;
      rxslip     <= 1'b0;
      slip_count <= 8'd0;
    end else begin
      state      <= state_n;
      sh_cnt     <= sh_cnt_n;
      inv_cnt    <= inv_cnt_n;
      good_win   <= good_win_n;
      wait_cnt   <= wait_cnt_n;
      block_lock <= lock_n;
      rxslip     <= rxslip_n;
      slip_count <= slip_count_n;
    end
endmodule

// File: rtl/eth_block_lock_multi.sv
// eth_block_lock_multi: N independent 10GBASE-R block-lock lanes plus a registered all-locked flag
module eth_block_lock_multi #(
  parameter int N_LANES        = 1,
  parameter int SH_CNT_MAX     = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int LOCK_WINDOWS   = 1,
  parameter int SLIP_WAIT      = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [2*N_LANES-1:0]   i_header,
  input  logic [N_LANES-1:0]     i_header_valid,
  input  logic                   i_clear_stats,
  output logic [N_LANES-1:0]     o_block_lock,
  output logic [N_LANES-1:0]     o_rxslip,
  output logic                   o_all_locked,
  output logic [8*N_LANES-1:0]   o_slip_count
);
  if (N_LANES < 1 || N_LANES > 8) begin : g_bad_lanes
    $error("N_LANES must be 1..8");
  end
  if (SH_CNT_MAX < 2) begin : g_bad_cnt
    $error("SH_CNT_MAX must be >= 2");
  end
  if (SH_INVALID_MAX < 1 || SH_INVALID_MAX > SH_CNT_MAX) begin : g_bad_inv
    $error("SH_INVALID_MAX must be 1..SH_CNT_MAX");
  end
  if (LOCK_WINDOWS < 1) begin : g_bad_win
    $error("LOCK_WINDOWS must be >= 1");
  end
  if (SLIP_WAIT < 0) begin : g_bad_wait
    $error("SLIP_WAIT must be >= 0");
  end
  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    eth_block_lock_lane #(
      .SH_CNT_MAX    (SH_CNT_MAX),
      .SH_INVALID_MAX(SH_INVALID_MAX),
      .LOCK_WINDOWS  (LOCK_WINDOWS),
      .SLIP_WAIT     (SLIP_WAIT)
    ) u_lane (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .header      (i_header[2*i+:2]),
      .header_valid(i_header_valid[i]),
      .clear_stats (i_clear_stats),
      .block_lock  (o_block_lock[i]),
      .rxslip      (o_rxslip[i]),
      .slip_count  (o_slip_count[8*i+:8])
    );
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) o_all_locked <= 1'b0;
    else o_all_locked <= &o_block_lock;
endmodule

// File: tb/tb_eth_block_lock_multi.sv
// tb_eth_block_lock_multi: randomized header streams checked per cycle against a window/holdoff reference model
module tb_eth_block_lock_multi;
  localparam int NL = 2, CM = 16, IM = 4, LW = 2, SW = 5;
  localparam int RATES [6] = '{0, 0, 5, 50, 100, 500};
  logic clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic [2*NL-1:0] hdr = '0;
  logic [NL-1:0] hv = '0, lock, rxslip;
  logic all;
  logic [8*NL-1:0] sc;
  eth_block_lock_multi #(
    .N_LANES(NL), .SH_CNT_MAX(CM), .SH_INVALID_MAX(IM), .LOCK_WINDOWS(LW), .SLIP_WAIT(SW)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_header(hdr), .i_header_valid(hv), .i_clear_stats(clr),
    .o_block_lock(lock), .o_rxslip(rxslip), .o_all_locked(all), .o_slip_count(sc)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic all;
    logic [NL-1:0] lock;
    logic [NL-1:0] rx;
    logic [8*NL-1:0] sc;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int tests = 0, fails = 0;
  int cyc, blind[NL], beats[NL], badc[NL], clean[NL], slips[NL], pbad[NL];
  bit locked[NL];
  bit prev_all;
  // Cycle numbering restarts at reset release; edge 0 is the INIT edge, evaluation from edge 1
  function automatic void model_reset();
    cyc = 0;
    prev_all = 0;
    for (int k = 0; k < NL; k++) begin
      blind[k] = 1; beats[k] = 0; badc[k] = 0; clean[k] = 0; slips[k] = 0; locked[k] = 0;
    end
  endfunction
  function automatic void step();
    exp_t x;
    bit nall = 1;
    x.all = prev_all;
    for (int k = 0; k < NL; k++) begin
      bit bad = !(hdr[2*k+:2] == 2'b01 || hdr[2*k+:2] == 2'b10);
      x.rx[k] = 0;
      if (hv[k] && cyc >= blind[k]) begin
        if ((!locked[k] && bad) || (locked[k] && badc[k] + int'(bad) == IM)) begin
          locked[k] = 0; clean[k] = 0; beats[k] = 0; badc[k] = 0;
          x.rx[k] = 1;
          if (slips[k] < 255) slips[k]++;
          blind[k] = cyc + 2 + SW;
        end else begin
          beats[k]++;
          badc[k] += int'(bad);
          if (beats[k] == CM) begin
            beats[k] = 0; badc[k] = 0;
            if (!locked[k]) begin
              clean[k]++;
              if (clean[k] == LW) locked[k] = 1;
            end
          end
        end
      end
      if (clr) slips[k] = 0;
      x.lock[k] = locked[k];
      x.sc[8*k+:8] = 8'(slips[k]);
      nall &= locked[k];
    end
    prev_all = nall;
    q.push_back(x);
    cyc++;
  endfunction
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({all, lock, rxslip, sc} !== e) begin
        fails++;
        $display("FAIL cycle_%0d: got all=%b lock=%b rxslip=%b cnt=%h, expected all=%b lock=%b rxslip=%b cnt=%h",
                 cyc - 1, all, lock, rxslip, sc, e.all, e.lock, e.rx, e.sc);
      end
    end
  end
  task automatic cycle(input int pval, input int pclr);
    for (int k = 0; k < NL; k++) begin
      hv[k] = $urandom_range(99) < pval;
      hdr[2*k+:2] = ($urandom_range(999) < pbad[k]) ? ($urandom_range(1) ? 2'b00 : 2'b11)
                                                     : ($urandom_range(1) ? 2'b01 : 2'b10);
    end
    clr = $urandom_range(999) < pclr;
    step();
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    #1;
    tests++;
    if ({all, lock, rxslip, sc} !== '0) begin
      fails++;
      $display("FAIL async_reset: got all=%b lock=%b rxslip=%b cnt=%h, expected all zero", all, lock, rxslip, sc);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({all, lock, rxslip, sc} !== '0) begin
      fails++;
      $display("FAIL reset_state: got all=%b lock=%b rxslip=%b cnt=%h, expected all zero", all, lock, rxslip, sc);
    end
    rst_n = 1'b1;
    model_reset();
    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < NL; k++) pbad[k] = RATES[$urandom_range(5)];
      repeat ($urandom_range(100, 300)) cycle($urandom_range(1) ? 100 : 75, 3);
      if (p % 8 == 7) begin
        pbad[0] = 1000;
        cycle(100, 0);
        do_reset();
      end
    end
    pbad[0] = 1000;
    pbad[1] = 0;
    repeat (300 * (SW + 2) + 50) cycle(100, 0);
    repeat (30) cycle(100, 1000);
    repeat (40) cycle(100, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
